// File: rtl/shake_absorb_loader.sv
// SHAKE128/256 input stage: packs header-framed message words into rate blocks,
// applies SHAKE padding and double-buffers one completed block for the permutation.
module shake_absorb_loader #(
  parameter int unsigned W     = 64,
  parameter int unsigned LEN_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [W-1:0]          data_in,
  input  logic [LEN_W-1:0]      len_in,
  input  logic                  mode_in,
  output logic                  ready_out,
  output logic [(1344/W)*W-1:0] block_out,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic                  block_last,
  output logic                  block_mode,
  output logic                  busy
);

  localparam int unsigned BPW            = W / 8;
  localparam int unsigned MAX_RATE_WORDS = 1344 / W;
  localparam int unsigned IW             = $clog2(MAX_RATE_WORDS + 1);
  localparam logic [IW-1:0] RateLast128  = IW'(1344 / W - 1);
  localparam logic [IW-1:0] RateLast256  = IW'(1088 / W - 1);

  typedef enum logic [1:0] {StIdle, StAbsorb, StFull} state_e;

  state_e                      r_state, w_state_next;
  logic                        r_mode;
  logic [LEN_W-1:0]            r_remaining, w_remaining_next;
  logic [IW-1:0]               r_word_idx;
  logic                        r_pad_done;
  logic [MAX_RATE_WORDS*W-1:0] r_asm;
  logic [MAX_RATE_WORDS*W-1:0] r_block_out;
  logic                        r_block_valid, r_block_last, r_block_mode;

  logic          w_ready;
  logic          w_hdr;
  logic          w_we;
  logic          w_set_pad;
  logic          w_load;
  logic [W-1:0]  w_word;
  logic [IW-1:0] w_last_idx;

  assign w_last_idx = r_mode ? RateLast256 : RateLast128;

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_ready          = 1'b0;
    w_hdr            = 1'b0;
    w_we             = 1'b0;
    w_set_pad        = 1'b0;
    w_load           = 1'b0;
    w_word           = '0;
    unique case (r_state)
      StIdle: begin
        w_ready = 1'b1;
        if (valid_in && !rst) begin
          w_hdr        = 1'b1;
          w_state_next = StAbsorb;
        end
      end
      StAbsorb: begin
        if (r_pad_done) begin
          w_we = 1'b1;
        end else if (r_remaining == '0) begin
          w_we        = 1'b1;
          w_set_pad   = 1'b1;
          w_word[7:0] = 8'h1F;
        end else if (r_remaining >= LEN_W'(BPW)) begin
          w_ready = 1'b1;
          if (valid_in && !rst) begin
            w_we             = 1'b1;
            w_word           = data_in;
            w_remaining_next = r_remaining - LEN_W'(BPW);
          end
        end else begin
          w_ready = 1'b1;
          if (valid_in && !rst) begin
            w_we             = 1'b1;
            w_set_pad        = 1'b1;
            w_remaining_next = '0;
            // Keep the valid tail bytes, drop the rest, domain byte right after.
            for (int b = 0; b < BPW; b++) begin
              if (LEN_W'(b) < r_remaining) begin
                w_word[b*8 +: 8] = data_in[b*8 +: 8];
              end else if (LEN_W'(b) == r_remaining) begin
                w_word[b*8 +: 8] = 8'h1F;
              end
            end
          end
        end
        if (w_we && (r_pad_done || w_set_pad) && (r_word_idx == w_last_idx)) begin
          w_word[W-1 -: 8] = w_word[W-1 -: 8] | 8'h80;
        end
        if (w_we && (r_word_idx == w_last_idx)) begin
          w_state_next = StFull;
        end
      end
      StFull: begin
        if (!r_block_valid || block_ready) begin
          w_load       = 1'b1;
          w_state_next = r_pad_done ? StIdle : StAbsorb;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_mode        <= 1'b0;
      r_remaining   <= '0;
      r_word_idx    <= '0;
      r_pad_done    <= 1'b0;
      r_asm         <= '0;
      r_block_out   <= '0;
      r_block_valid <= 1'b0;
      r_block_last  <= 1'b0;
      r_block_mode  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_hdr) begin
        r_mode      <= mode_in;
        r_remaining <= len_in;
        r_word_idx  <= '0;
        r_pad_done  <= 1'b0;
        r_asm       <= '0;
      end
      if (w_we) begin
        for (int i = 0; i < MAX_RATE_WORDS; i++) begin
          if (r_word_idx == IW'(i)) begin
            r_asm[i*W +: W] <= w_word;
          end
        end
        r_word_idx  <= r_word_idx + 1'b1;
        r_remaining <= w_remaining_next;
        if (w_set_pad) begin
          r_pad_done <= 1'b1;
        end
      end
      // A reload in the same cycle as a consumer handshake keeps block_valid high.
      if (w_load) begin
        r_block_out   <= r_asm;
        r_block_valid <= 1'b1;
        r_block_last  <= r_pad_done;
        r_block_mode  <= r_mode;
        r_asm         <= '0;
        r_word_idx    <= '0;
      end else if (block_ready) begin
        r_block_valid <= 1'b0;
      end
    end
  end

  assign ready_out   = w_ready && !rst;
  assign block_out   = r_block_out;
  assign block_valid = r_block_valid;
  assign block_last  = r_block_last;
  assign block_mode  = r_block_mode;
  assign busy        = (r_state != StIdle);

endmodule
